// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, frame FSM states and key event type for the PS/2 receiver
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - key event valid/ready stream between the receiver and the display stage
interface ps2_kbd_rx_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;

    modport master (output evt_valid, output evt_code, output evt_break, output evt_ext, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_break, input evt_ext, output evt_ready);

endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchronizers, falling-edge detect and 11-bit frame deframer
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT     = 5000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_q;
    ps2_state_e             r_state;
    logic [3:0]             r_bitcnt;
    logic [9:0]             r_sh;
    logic [TW-1:0]          r_tmo;
    logic                   w_clk;
    logic                   w_dat;
    logic                   w_fall;

    assign w_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat  = r_dat_sync[SYNC_STAGES-1];
    assign w_fall = r_clk_q & ~w_clk;

    // Synchronizers idle high so a reset never fabricates a falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_q    <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_q    <= w_clk;
        end
    end

    // r_sh ends up as {stop, parity, data[7:0]} after ten shifts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= '0;
            r_sh         <= '0;
            r_tmo        <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (w_fall) begin
                        if (!w_dat) begin
                            r_state  <= ST_SHIFT;
                            r_bitcnt <= 4'd1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_sh     <= {w_dat, r_sh[9:1]};
                        r_tmo    <= '0;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd10) r_state <= ST_CHECK;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        o_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_sh[9] && (^r_sh[8:0])) begin
                        o_byte       <= r_sh[7:0];
                        o_byte_valid <= 1'b1;
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: deframer, E0/F0 prefix folding and event FIFO
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT     = 5000,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_kbd_rx_if.master   evt,
    output logic           frame_err,
    output logic           overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        w_frame_err;
    logic        r_ext_f;
    logic        r_brk_f;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_wr;
    ps2_evt_t    w_evt;
    ps2_evt_t    w_head;
    ps2_evt_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    ps2_frame_rx #(
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign frame_err = w_frame_err;

    always_comb begin
        w_push   = w_byte_valid && (w_byte != PS2_EXT) && (w_byte != PS2_BRK);
        w_evt    = '0;
        w_evt.ext  = r_ext_f;
        w_evt.brk  = r_brk_f;
        w_evt.code = w_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
        end else if (w_frame_err || w_push) begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
        end else if (w_byte_valid) begin
            if (w_byte == PS2_EXT) r_ext_f <= 1'b1;
            if (w_byte == PS2_BRK) r_brk_f <= 1'b1;
        end
    end

    // A pop on the same cycle frees the slot, so a full FIFO can still accept
    assign w_pop  = evt.evt_valid && evt.evt_ready;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_evt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) overflow <= 1'b1;
        end
    end

    // Head is gated so the outputs read zero while the FIFO is empty
    assign w_head        = r_mem[r_rd_ptr];
    assign evt.evt_valid = (r_count != '0);
    assign evt.evt_code  = evt.evt_valid ? w_head.code : 8'h00;
    assign evt.evt_break = evt.evt_valid & w_head.brk;
    assign evt.evt_ext   = evt.evt_valid & w_head.ext;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - randomized self-checking bench for ps2_kbd_rx against a byte-level key event model
module tb_ps2_kbd_rx;

    localparam int DEPTH = 8;
    localparam int HALF  = 25;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic frame_err;
    logic overflow;

    ps2_kbd_rx_if u_if ();

    ps2_kbd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT     (5000),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt       (u_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int m_err    = 0;
    int n_pops   = 0;
    bit m_ext    = 1'b0;
    bit m_brk    = 1'b0;
    bit m_ovf    = 1'b0;
    bit rnd_done = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] last_pop = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Key event rules applied to whole bytes: prefixes set flags, any other byte makes an event
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        ps2_data = bits[10];
        wait_clk(HALF);
        ps2_clk = 1'b0;
        if (bad_par) model_err();
        else model_byte(b);
        wait_clk(HALF);
        ps2_clk = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    endtask

    task automatic settle();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
        wait_clk(20);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_err_count", err_cnt, m_err);
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Event scoreboard plus hold-stability check while the consumer stalls
    logic       p_hold = 1'b0;
    logic [9:0] p_vals = '0;
    always @(negedge clk) begin
        if (rst && u_if.evt_valid) begin
            if (p_hold) chk("evt_stable", 32'({u_if.evt_ext, u_if.evt_break, u_if.evt_code}), 32'(p_vals));
            if (u_if.evt_ready) begin
                n_pops++;
                last_pop = {u_if.evt_ext, u_if.evt_break, u_if.evt_code};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL evt_spurious actual=%h expected=none t=%0t", last_pop, $time);
                end else begin
                    chk("evt", 32'(last_pop), 32'(exp_q.pop_front()));
                end
            end
        end
        p_hold = rst && u_if.evt_valid && !u_if.evt_ready;
        p_vals = {u_if.evt_ext, u_if.evt_break, u_if.evt_code};
    end

    logic prev_err = 1'b0;
    always @(negedge clk) begin
        if (frame_err) begin
            err_cnt++;
            chk("frame_err_width", 32'(prev_err), 32'd0);
        end
        prev_err = frame_err;
    end

    initial begin
        int pops0;
        logic [7:0] rb;
        int sel;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        u_if.evt_ready = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("rst_evt_valid", 32'(u_if.evt_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_evt_code", 32'(u_if.evt_code), 0);
        wait_clk(5);
        rst = 1'b1;
        wait_clk(5);

        send_frame(8'h1C, 1'b0);
        settle();
        chk("t1_event", 32'(last_pop), 32'h01C);

        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        settle();
        chk("t2_break", 32'(last_pop), 32'h11C);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        settle();
        chk("t2_ext_break", 32'(last_pop), 32'h375);

        send_frame(8'h1C, 1'b1);
        settle();
        send_frame(8'h32, 1'b0);
        settle();
        chk("t3_after_err", 32'(last_pop), 32'h032);

        send_partial(8'h5A, 6);
        wait_clk(5100);
        model_err();
        send_frame(8'h1C, 1'b0);
        settle();
        chk("t4_after_timeout", 32'(last_pop), 32'h01C);

        u_if.evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_frame(8'h15 + 8'(i), 1'b0);
        wait_clk(20);
        chk("t5_valid_full", 32'(u_if.evt_valid), 1);
        chk("t5_overflow", 32'(overflow), 1);
        chk("t5_head", 32'({u_if.evt_ext, u_if.evt_break, u_if.evt_code}), 32'h015);
        pops0 = n_pops;
        u_if.evt_ready = 1'b1;
        settle();
        chk("t5_drain_count", n_pops - pops0, 8);
        chk("t5_empty", 32'(u_if.evt_valid), 0);

        u_if.evt_ready = 1'b0;
        send_frame(8'h2A, 1'b0);
        send_partial(8'h44, 5);
        rst = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(u_if.evt_valid), 0);
        chk("t6_overflow_rst", 32'(overflow), 0);
        exp_q.delete();
        m_ovf = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        u_if.evt_ready = 1'b1;
        wait_clk(5);
        pops0 = n_pops;
        send_frame(8'h1C, 1'b0);
        settle();
        chk("t6_one_event", n_pops - pops0, 1);
        chk("t6_event", 32'(last_pop), 32'h01C);

        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    sel = $urandom_range(0, 9);
                    rb  = 8'($urandom_range(1, 8'hDF));
                    if (sel == 0) send_frame(8'hE0, 1'b0);
                    else if (sel == 1) send_frame(8'hF0, 1'b0);
                    else if (sel == 2) send_frame(rb, 1'b1);
                    else send_frame(rb, 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    u_if.evt_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        u_if.evt_ready = 1'b1;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
